// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} rst_state_e;

  function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
    int m;
    m = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Warm-reset handshake and per-domain reset outputs of the reset sequencer.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_rst_req;
  logic                   sw_rst_ack;
  logic [NUM_DOMAINS-1:0] rstn_out;
  logic                   rst_done;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack,
    input  rstn_out,
    input  rst_done
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack,
    output rstn_out,
    output rst_done
  );
endinterface

// File: rtl/reset_sync.sv
// Async-assert / sync-release flop chain; rst_sync goes high STAGES edges after rst falls.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / warm reset sequencer: hold all domains, then release rstn_out in staggered index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int NUM_DOMAINS    = 4,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.slave   bus
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  rst_state_e             state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   warm;
  logic                   ack_q;
  logic                   done_q;
  logic [NUM_DOMAINS-1:0] rstn_q;
  logic                   rst_sync;

  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ASSERT;
      cnt    <= '0;
      idx    <= '0;
      warm   <= 1'b0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      rstn_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ASSERT: begin
          rstn_q <= '0;
          done_q <= 1'b0;
          cnt    <= '0;
          if (rst_sync) state <= HOLD;
        end
        HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt       <= '0;
            idx       <= IW'(1);
            rstn_q[0] <= 1'b1;
            if (NUM_DOMAINS == 1) begin
              state  <= RUN;
              done_q <= 1'b1;
              ack_q  <= warm;
              warm   <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == CW'(STAGGER_CYCLES - 1)) begin
            cnt         <= '0;
            rstn_q[idx] <= 1'b1;
            idx         <= idx + IW'(1);
            if (idx == IW'(NUM_DOMAINS - 1)) begin
              state  <= RUN;
              done_q <= 1'b1;
              ack_q  <= warm;
              warm   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          // A request seen while the ack is still high is the tail of the previous one.
          if (bus.sw_rst_req && !ack_q) begin
            state  <= HOLD;
            cnt    <= '0;
            rstn_q <= '0;
            done_q <= 1'b0;
            warm   <= 1'b1;
          end
        end
        default: state <= ASSERT;
      endcase
    end
  end

  assign bus.sw_rst_ack = ack_q;
  assign bus.rstn_out   = rstn_q;
  assign bus.rst_done   = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on table, async assert, warm resets, held request, abort.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   ack_cnt = 0;

  reset_sequencer_if #(.NUM_DOMAINS(4)) bus ();

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_DOMAINS(4), .STAGGER_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic       req;
    logic [3:0] rstn;
    logic       done;
  } vec_t;

  vec_t pon [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (bus.sw_rst_ack === 1'b1) ack_cnt++;
  endtask

  // Releases rst (called with rst high, just after an edge) and walks the power-on table.
  task automatic power_on(input string nm);
    int a0;
    a0 = ack_cnt;
    rst = 1'b0;
    edge_n = 0;
    chk({nm, " rstn@0"}, 32'(bus.rstn_out), 32'h0);
    for (int i = 0; i < 10; i++) begin
      while (edge_n < pon[i].e) step();
      chk($sformatf("%s rstn@%0d", nm, pon[i].e), 32'(bus.rstn_out), 32'(pon[i].rstn));
      chk($sformatf("%s done@%0d", nm, pon[i].e), 32'(bus.rst_done), 32'(pon[i].done));
      bus.sw_rst_req = pon[i].req;
    end
    bus.sw_rst_req = 1'b0;
    while (edge_n < 40) step();
    chk({nm, " rstn@40"}, 32'(bus.rstn_out), 32'hf);
    chk({nm, " no ack"}, 32'(ack_cnt - a0), 32'd0);
  endtask

  // One-cycle warm request; optionally a stray request poke_at edges later that must be ignored.
  task automatic warm(input string nm, input int poke_at);
    int a0;
    a0 = ack_cnt;
    bus.sw_rst_req = 1'b1;
    step();
    bus.sw_rst_req = 1'b0;
    chk({nm, " rstn@t"}, 32'(bus.rstn_out), 32'h0);
    chk({nm, " done@t"}, 32'(bus.rst_done), 32'h0);
    for (int r = 1; r <= 29; r++) begin
      step();
      bus.sw_rst_req = (r == poke_at);
      case (r)
        15: chk({nm, " rstn@t+15"}, 32'(bus.rstn_out), 32'h0);
        16: chk({nm, " rstn@t+16"}, 32'(bus.rstn_out), 32'h1);
        20: chk({nm, " rstn@t+20"}, 32'(bus.rstn_out), 32'h3);
        27: begin
          chk({nm, " rstn@t+27"}, 32'(bus.rstn_out), 32'h7);
          chk({nm, " ack@t+27"}, 32'(bus.sw_rst_ack), 32'h0);
        end
        28: begin
          chk({nm, " rstn@t+28"}, 32'(bus.rstn_out), 32'hf);
          chk({nm, " done@t+28"}, 32'(bus.rst_done), 32'h1);
          chk({nm, " ack@t+28"}, 32'(bus.sw_rst_ack), 32'h1);
        end
        29: begin
          chk({nm, " ack@t+29"}, 32'(bus.sw_rst_ack), 32'h0);
          chk({nm, " rstn@t+29"}, 32'(bus.rstn_out), 32'hf);
        end
        default: ;
      endcase
    end
    bus.sw_rst_req = 1'b0;
    chk({nm, " ack count"}, 32'(ack_cnt - a0), 32'd1);
  endtask

  initial begin
    pon[0] = '{e: 2,  req: 1'b0, rstn: 4'b0000, done: 1'b0};
    pon[1] = '{e: 3,  req: 1'b1, rstn: 4'b0000, done: 1'b0};
    pon[2] = '{e: 18, req: 1'b0, rstn: 4'b0000, done: 1'b0};
    pon[3] = '{e: 19, req: 1'b0, rstn: 4'b0001, done: 1'b0};
    pon[4] = '{e: 22, req: 1'b0, rstn: 4'b0001, done: 1'b0};
    pon[5] = '{e: 23, req: 1'b1, rstn: 4'b0011, done: 1'b0};
    pon[6] = '{e: 26, req: 1'b0, rstn: 4'b0011, done: 1'b0};
    pon[7] = '{e: 27, req: 1'b0, rstn: 4'b0111, done: 1'b0};
    pon[8] = '{e: 30, req: 1'b0, rstn: 4'b0111, done: 1'b0};
    pon[9] = '{e: 31, req: 1'b0, rstn: 4'b1111, done: 1'b1};

    rst = 1'b1;
    bus.sw_rst_req = 1'b0;
    #1;
    chk("reset rstn", 32'(bus.rstn_out), 32'h0);
    chk("reset done", 32'(bus.rst_done), 32'h0);
    chk("reset ack", 32'(bus.sw_rst_ack), 32'h0);
    repeat (5) step();
    power_on("pon");

    // Asynchronous assert between edges, no clock edge needed.
    #3;
    rst = 1'b1;
    #1;
    chk("async rstn", 32'(bus.rstn_out), 32'h0);
    chk("async done", 32'(bus.rst_done), 32'h0);
    chk("async ack", 32'(bus.sw_rst_ack), 32'h0);
    step();
    step();
    power_on("repon");

    warm("warm", -1);
    step();
    warm("ign_hold", 5);
    step();
    warm("ign_rel", 22);
    step();

    // Held request: back-to-back warm resets.
    begin
      int a0;
      a0 = ack_cnt;
      bus.sw_rst_req = 1'b1;
      step();
      chk("held rstn@t", 32'(bus.rstn_out), 32'h0);
      for (int r = 1; r <= 58; r++) begin
        step();
        case (r)
          28: begin
            chk("held ack@t+28", 32'(bus.sw_rst_ack), 32'h1);
            chk("held rstn@t+28", 32'(bus.rstn_out), 32'hf);
          end
          29: begin
            chk("held ack@t+29", 32'(bus.sw_rst_ack), 32'h0);
            chk("held rstn@t+29", 32'(bus.rstn_out), 32'hf);
          end
          30: begin
            chk("held rstn@t+30", 32'(bus.rstn_out), 32'h0);
            chk("held done@t+30", 32'(bus.rst_done), 32'h0);
            bus.sw_rst_req = 1'b0;
          end
          46: chk("held rstn@t+46", 32'(bus.rstn_out), 32'h1);
          58: begin
            chk("held ack@t+58", 32'(bus.sw_rst_ack), 32'h1);
            chk("held rstn@t+58", 32'(bus.rstn_out), 32'hf);
          end
          default: ;
        endcase
      end
      step();
      chk("held ack count", 32'(ack_cnt - a0), 32'd2);
    end

    // Abort in RELEASE while rstn_out = 0011.
    rst = 1'b1;
    step();
    rst = 1'b0;
    edge_n = 0;
    while (edge_n < 24) step();
    chk("abort pre rstn", 32'(bus.rstn_out), 32'h3);
    #3;
    rst = 1'b1;
    #1;
    chk("abort rstn", 32'(bus.rstn_out), 32'h0);
    chk("abort done", 32'(bus.rst_done), 32'h0);
    step();
    step();
    power_on("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
